mem_arbiter: RTL and testbench

Two-port arbiter that shares the single off-chip data memory port (256-bit line interface with `mem_ack_i` handshake) between the instruction-cache refill path (port 0) and `dcache_top` (port 1). It sits between the caches and the data memory model. It applies round-robin priority, latches one requester's transaction onto the memory port until `mem_ack_i`, and returns the read line and a one-cycle acknowledge to that requester only. It also keeps per-port completed-transaction counters for performance debug.

---
 rtl/mem_arbiter_if.sv | 35 +++
 rtl/mem_arbiter.sv | 66 ++++++
 tb/tb_mem_arbiter.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: both cache request ports plus the shared memory line port.
// slave is the arbiter view; master is the cache/memory side that drives it.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 256,
    parameter int CNT_W  = 16
);
    logic              p0_enable_i, p1_enable_i;
    logic              p0_write_i, p1_write_i;
    logic [ADDR_W-1:0] p0_addr_i, p1_addr_i;
    logic [DATA_W-1:0] p0_data_i, p1_data_i;
    logic              p0_ack_o, p1_ack_o;
    logic [DATA_W-1:0] p0_data_o, p1_data_o;
    logic              mem_enable_o, mem_write_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_data_o, mem_data_i;
    logic              mem_ack_i;
    logic [CNT_W-1:0]  p0_count_o, p1_count_o;
    modport slave (
        input  p0_enable_i, p1_enable_i, p0_write_i, p1_write_i,
        input  p0_addr_i, p1_addr_i, p0_data_i, p1_data_i,
        input  mem_data_i, mem_ack_i,
        output p0_ack_o, p1_ack_o, p0_data_o, p1_data_o,
        output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
        output p0_count_o, p1_count_o
    );
    modport master (
        output p0_enable_i, p1_enable_i, p0_write_i, p1_write_i,
        output p0_addr_i, p1_addr_i, p0_data_i, p1_data_i,
        output mem_data_i, mem_ack_i,
        input  p0_ack_o, p1_ack_o, p0_data_o, p1_data_o,
        input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
        input  p0_count_o, p1_count_o
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin share of one memory line port between icache refill (p0) and dcache (p1).
// Latches the winner onto the memory port until mem_ack_i, then idles one RELEASE cycle.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 256,
    parameter int CNT_W  = 16
) (
    input logic          clk_i,
    input logic          rst_i,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;
    state_t state, state_nx;
    logic grant, last, win, start, done;
    always_ff @(posedge clk_i or negedge rst_i)
        if (!rst_i) state <= IDLE;
        else state <= state_nx;
    always_comb begin
        state_nx = (state == IDLE) ? (start ? BUSY : IDLE) :
                   (state == BUSY) ? (done ? RELEASE : BUSY) : IDLE;
    end
    // on a tie the port not served last wins
    always_comb begin
        win   = (bus.p0_enable_i && bus.p1_enable_i) ? !last : bus.p1_enable_i;
        start = (state == IDLE) && (bus.p0_enable_i || bus.p1_enable_i);
        done  = (state == BUSY) && bus.mem_ack_i;
    end
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            grant            <= 1'b0;
            last             <= 1'b1;
            bus.mem_enable_o <= 1'b0;
            bus.mem_write_o  <= 1'b0;
            bus.mem_addr_o   <= {ADDR_W{1'b0}};
            bus.mem_data_o   <= {DATA_W{1'b0}};
            bus.p0_ack_o     <= 1'b0;
            bus.p1_ack_o     <= 1'b0;
            bus.p0_data_o    <= {DATA_W{1'b0}};
            bus.p1_data_o    <= {DATA_W{1'b0}};
            bus.p0_count_o   <= {CNT_W{1'b0}};
            bus.p1_count_o   <= {CNT_W{1'b0}};
        end else begin
            bus.p0_ack_o <= done && !grant;
            bus.p1_ack_o <= done && grant;
            if (start) begin
                grant            <= win;
                bus.mem_enable_o <= 1'b1;
                bus.mem_write_o  <= win ? bus.p1_write_i : bus.p0_write_i;
                bus.mem_addr_o   <= win ? bus.p1_addr_i : bus.p0_addr_i;
                bus.mem_data_o   <= win ? bus.p1_data_i : bus.p0_data_i;
            end
            if (done) begin
                bus.mem_enable_o <= 1'b0;
                bus.mem_write_o  <= 1'b0;
                last             <= grant;
                if (!grant) begin
                    bus.p0_count_o <= bus.p0_count_o + CNT_W'(1);
                    if (!bus.mem_write_o) bus.p0_data_o <= bus.mem_data_i;
                end else begin
                    bus.p1_count_o <= bus.p1_count_o + CNT_W'(1);
                    if (!bus.mem_write_o) bus.p1_data_o <= bus.mem_data_i;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed requests push expected completions into a scoreboard; a memory
// model acks after a set latency and a monitor checks every port ack against the queue.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 256;
    localparam int CW = 4;
    typedef struct {
        logic          p;
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        logic [DW-1:0] rd;
        logic [CW-1:0] cnt;
    } exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) bus();
    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (.clk_i(clk), .rst_i(rst_n), .bus(bus));
    int total = 0;
    int bad = 0;
    int lat = 2;
    int mcnt = 0;
    logic model_ack = 1'b0;
    logic spur_ack = 1'b0;
    logic [DW-1:0] model_data = '0;
    logic snap_w = 1'b0;
    logic stable = 1'b0;
    logic [AW-1:0] snap_a = '0;
    logic [DW-1:0] snap_d = '0;
    logic [DW-1:0] exp_data [2];
    logic [CW-1:0] exp_cnt [2];
    exp_t sb [$];
    assign bus.mem_ack_i  = model_ack | spur_ack;
    assign bus.mem_data_i = model_data;

    function automatic logic [DW-1:0] line_of(input logic [AW-1:0] a);
        return {{7{a}}, a ^ 32'hDEADBEEF ^ 32'h20};
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic rst_chk(input string tag);
        chk({tag, "_ctrl"}, {bus.mem_enable_o, bus.mem_write_o, bus.p0_ack_o, bus.p1_ack_o,
                             bus.mem_addr_o, bus.p0_count_o, bus.p1_count_o}, '0);
        chk({tag, "_mem_data"}, bus.mem_data_o, '0);
        chk({tag, "_p0_data"}, bus.p0_data_o, '0);
        chk({tag, "_p1_data"}, bus.p1_data_o, '0);
    endtask

    task automatic push(input logic p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_t e;
        if (!w) exp_data[p] = line_of(a);
        exp_cnt[p] = exp_cnt[p] + 1'b1;
        e.p = p; e.w = w; e.a = a; e.wd = d; e.rd = exp_data[p]; e.cnt = exp_cnt[p];
        sb.push_back(e);
    endtask

    // chg scribbles over the address mid-transaction to prove the latched copy is used
    task automatic req(input logic p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit chg);
        bit got = 1'b0;
        if (p) begin bus.p1_write_i = w; bus.p1_addr_i = a; bus.p1_data_i = d; bus.p1_enable_i = 1'b1; end
        else begin bus.p0_write_i = w; bus.p0_addr_i = a; bus.p0_data_i = d; bus.p0_enable_i = 1'b1; end
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (chg && i == 3) begin
                if (p) bus.p1_addr_i = ~a;
                else bus.p0_addr_i = ~a;
            end
            got = p ? bus.p1_ack_o : bus.p0_ack_o;
        end
        if (p) bus.p1_enable_i = 1'b0;
        else bus.p0_enable_i = 1'b0;
        chk(p ? "p1_ack_seen" : "p0_ack_seen", got, 1);
    endtask

    // memory model: snapshot request on first enabled cycle, flag any change, ack after lat cycles
    initial forever begin
        @(negedge clk);
        model_ack = 1'b0;
        if (!bus.mem_enable_o) mcnt = 0;
        else begin
            if (mcnt == 0) begin
                snap_w = bus.mem_write_o; snap_a = bus.mem_addr_o; snap_d = bus.mem_data_o; stable = 1'b1;
            end else if ({bus.mem_write_o, bus.mem_addr_o, bus.mem_data_o} !== {snap_w, snap_a, snap_d})
                stable = 1'b0;
            mcnt++;
            if (mcnt == lat) begin
                model_ack = 1'b1;
                model_data = line_of(bus.mem_addr_o);
                mcnt = 0;
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.p0_ack_o || bus.p1_ack_o) begin
                if (sb.size() == 0) chk("unexpected_ack", {bus.p1_ack_o, bus.p0_ack_o}, 2'b00);
                else begin
                    e = sb.pop_front();
                    chk("ack_port", {bus.p1_ack_o, bus.p0_ack_o}, e.p ? 2'b10 : 2'b01);
                    chk("port_data", e.p ? bus.p1_data_o : bus.p0_data_o, e.rd);
                    chk("port_count", e.p ? bus.p1_count_o : bus.p0_count_o, e.cnt);
                    chk("mem_addr", snap_a, e.a);
                    chk("mem_write", snap_w, e.w);
                    chk("mem_wdata", snap_d, e.wd);
                    chk("mem_req_held", stable, 1);
                    chk("mem_released", {bus.mem_enable_o, bus.mem_write_o}, 2'b00);
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        bus.p0_enable_i = 0; bus.p0_write_i = 0; bus.p0_addr_i = '0; bus.p0_data_i = '0;
        bus.p1_enable_i = 0; bus.p1_write_i = 0; bus.p1_addr_i = '0; bus.p1_data_i = '0;
        exp_data[0] = '0; exp_data[1] = '0; exp_cnt[0] = '0; exp_cnt[1] = '0;
        repeat (2) @(negedge clk);
        rst_chk("reset");
        rst_n = 1'b1;
        // reset abandons an in-flight p1 read; a late memory ack must be ignored
        lat = 10;
        bus.p1_addr_i = 32'h300; bus.p1_enable_i = 1'b1;
        repeat (4) @(negedge clk);
        chk("busy_before_rst", bus.mem_enable_o, 1);
        #2 rst_n = 1'b0;
        #1 rst_chk("mid_busy_rst");
        bus.p1_enable_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        spur_ack = 1'b1;
        @(negedge clk);
        spur_ack = 1'b0;
        chk("idle_spur_ack", {bus.p0_ack_o, bus.p1_ack_o}, 2'b00);
        chk("idle_spur_cnt", {bus.p0_count_o, bus.p1_count_o}, '0);
        // both ports hammer the arbiter: expect p0 first, then strict alternation
        lat = 2;
        for (int k = 0; k < 4; k++) begin
            push(0, 0, 32'h100 + 32'(k) * 32'h40, '0);
            push(1, 1, 32'h200 + 32'(k) * 32'h40, {8{32'h11110000 + 32'(k)}});
        end
        fork
            for (int k = 0; k < 4; k++) req(0, 0, 32'h100 + 32'(k) * 32'h40, '0, 0);
            for (int j = 0; j < 4; j++) req(1, 1, 32'h200 + 32'(j) * 32'h40, {8{32'h11110000 + 32'(j)}}, 0);
        join
        chk("rr_p0_count", bus.p0_count_o, 4);
        chk("rr_p1_count", bus.p1_count_o, 4);
        lat = 10;
        push(1, 1, 32'h400, {32{8'hA5}});
        req(1, 1, 32'h400, {32{8'hA5}}, 0);
        chk("p1_write_keeps_data", bus.p1_data_o, '0);
        lat = 3;
        push(0, 0, 32'h20, '0);
        req(0, 0, 32'h20, '0, 0);
        spur_ack = 1'b1;
        @(negedge clk);
        spur_ack = 1'b0;
        chk("release_spur_ack", {bus.p0_ack_o, bus.p1_ack_o}, 2'b00);
        repeat (2) @(negedge clk);
        chk("release_spur_cnt", bus.p0_count_o, 5);
        chk("p0_read_held", bus.p0_data_o[31:0], 32'hDEADBEEF);
        lat = 8;
        push(1, 0, 32'h500, '0);
        req(1, 0, 32'h500, '0, 1);
        lat = 1;
        n = 16 - int'(exp_cnt[0]);
        for (int i = 0; i < n; i++) begin
            push(0, 0, 32'h1000 + 32'(i), '0);
            req(0, 0, 32'h1000 + 32'(i), '0, 0);
        end
        chk("p0_wrap0", bus.p0_count_o, 0);
        push(0, 0, 32'h2000, '0);
        req(0, 0, 32'h2000, '0, 0);
        chk("p0_wrap1", bus.p0_count_o, 1);
        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
